// File: rtl/fetch_pc_predictor.sv
// fetch_pc_predictor
//   Front-end PC generator with a direct-mapped branch target buffer (BTB).
//   Every cycle it presents the fetch PC, together with a predicted next PC and a
//   next-is-sequential flag that travel down the pipe. Only execute-stage mispredict
//   redirects train the BTB.
//
// Ports
//   i_clk           clock
//   i_reset         synchronous, active-high reset
//   i_stall         downstream stall; holds the fetch PC
//   exec_ld_pc      execute redirect strobe
//   exec_br_pc      correct next PC of the redirecting instruction
//   exec_br_origin  PC of the redirecting instruction
//   f_pc            current fetch PC (registered)
//   f_predicted_pc  predicted PC of the instruction after f_pc
//   f_next_is_cont  1 when f_predicted_pc == f_pc + PC_INC
//   f_btb_hit       BTB hit for f_pc
//   redirect_count  accepted redirects (wraps)
//   btb_hit_count   unstalled, non-redirect cycles with a BTB hit (wraps)
module fetch_pc_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        exec_ld_pc,
  input  logic [31:0] exec_br_pc,
  input  logic [31:0] exec_br_origin,
  output logic [31:0] f_pc,
  output logic [31:0] f_predicted_pc,
  output logic        f_next_is_cont,
  output logic        f_btb_hit,
  output logic [31:0] redirect_count,
  output logic [31:0] btb_hit_count
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = 32 - IDXW - 2;

  logic [31:0]      r_pc;
  logic [31:0]      r_redirect_count;
  logic [31:0]      r_btb_hit_count;
  logic [ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]  r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];

  // Lookup side (current fetch PC)
  logic [IDXW-1:0]  w_idx;
  logic [TAGW-1:0]  w_tag;
  logic             w_hit;
  logic [31:0]      w_seq_pc;
  logic [31:0]      w_pred_pc;

  // Training side (redirecting instruction)
  logic [IDXW-1:0]  w_t_idx;
  logic [TAGW-1:0]  w_t_tag;
  logic             w_t_hit;
  logic             w_t_seq;

  always_comb begin
    w_idx     = r_pc[IDXW+1:2];
    w_tag     = r_pc[31:IDXW+2];
    w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_seq_pc  = r_pc + PC_INC;
    w_pred_pc = w_hit ? r_target[w_idx] : w_seq_pc;
  end

  always_comb begin
    w_t_idx = exec_br_origin[IDXW+1:2];
    w_t_tag = exec_br_origin[31:IDXW+2];
    w_t_hit = r_valid[w_t_idx] && (r_tag[w_t_idx] == w_t_tag);
    w_t_seq = (exec_br_pc == exec_br_origin + PC_INC);
  end

  // PC register and counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc             <= RESET_PC;
      r_redirect_count <= 32'd0;
      r_btb_hit_count  <= 32'd0;
    end else begin
      if (exec_ld_pc) begin
        r_pc <= exec_br_pc;
      end else if (!i_stall) begin
        r_pc <= w_pred_pc;
      end
      if (exec_ld_pc) begin
        r_redirect_count <= r_redirect_count + 32'd1;
      end
      if (w_hit && !i_stall && !exec_ld_pc) begin
        r_btb_hit_count <= r_btb_hit_count + 32'd1;
      end
    end
  end

  // Valid bits. A sequential redirect only clears the entry if it actually belongs to
  // the origin PC, so an unrelated alias at the same index survives.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else if (exec_ld_pc) begin
      if (!w_t_seq) begin
        r_valid[w_t_idx] <= 1'b1;
      end else if (w_t_hit) begin
        r_valid[w_t_idx] <= 1'b0;
      end
    end
  end

  // Tag/target storage needs no reset; valid bits gate every use.
  always_ff @(posedge i_clk) begin
    if (!i_reset && exec_ld_pc && !w_t_seq) begin
      r_tag[w_t_idx]    <= w_t_tag;
      r_target[w_t_idx] <= exec_br_pc;
    end
  end

  assign f_pc           = r_pc;
  assign f_predicted_pc = w_pred_pc;
  assign f_next_is_cont = (w_pred_pc == w_seq_pc);
  assign f_btb_hit      = w_hit;
  assign redirect_count = r_redirect_count;
  assign btb_hit_count  = r_btb_hit_count;

endmodule

// File: tb/tb_fetch_pc_predictor.sv
module tb_fetch_pc_predictor;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        exec_ld_pc;
  logic [31:0] exec_br_pc;
  logic [31:0] exec_br_origin;
  logic [31:0] f_pc;
  logic [31:0] f_predicted_pc;
  logic        f_next_is_cont;
  logic        f_btb_hit;
  logic [31:0] redirect_count;
  logic [31:0] btb_hit_count;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  fetch_pc_predictor #(
    .ENTRIES  (16),
    .RESET_PC (32'h0),
    .PC_INC   (32'd4)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_stall        (i_stall),
    .exec_ld_pc     (exec_ld_pc),
    .exec_br_pc     (exec_br_pc),
    .exec_br_origin (exec_br_origin),
    .f_pc           (f_pc),
    .f_predicted_pc (f_predicted_pc),
    .f_next_is_cont (f_next_is_cont),
    .f_btb_hit      (f_btb_hit),
    .redirect_count (redirect_count),
    .btb_hit_count  (btb_hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] origin, input logic [31:0] target);
    exec_ld_pc     = 1'b1;
    exec_br_origin = origin;
    exec_br_pc     = target;
    tick();
    exec_ld_pc     = 1'b0;
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] pc, input logic [31:0] pred,
                           input logic cont, input logic hit);
    chk({tag, "_pc"}, f_pc, pc);
    chk({tag, "_pred"}, f_predicted_pc, pred);
    chk({tag, "_cont"}, {31'd0, f_next_is_cont}, {31'd0, cont});
    chk({tag, "_hit"}, {31'd0, f_btb_hit}, {31'd0, hit});
  endtask

  initial begin
    i_reset        = 1'b1;
    i_stall        = 1'b0;
    exec_ld_pc     = 1'b0;
    exec_br_pc     = 32'h0;
    exec_br_origin = 32'h0;
    tick();
    tick();

    // 1. Reset state and sequential fetch
    chk_fetch("rst", 32'h0, 32'h4, 1'b1, 1'b0);
    chk("rst_rcnt", redirect_count, 32'd0);
    chk("rst_hcnt", btb_hit_count, 32'd0);
    i_reset = 1'b0;
    tick();
    chk_fetch("seq4", 32'h4, 32'h8, 1'b1, 1'b0);
    tick();
    chk_fetch("seq8", 32'h8, 32'hC, 1'b1, 1'b0);
    tick();
    chk_fetch("seqC", 32'hC, 32'h10, 1'b1, 1'b0);

    // 2. Install 0x10 -> 0x40
    redirect(32'h10, 32'h40);
    chk_fetch("inst", 32'h40, 32'h44, 1'b1, 1'b0);
    chk("inst_rcnt", redirect_count, 32'd1);
    redirect(32'hC, 32'h10);  // sequential, reaches 0x10 without training
    chk_fetch("hit10", 32'h10, 32'h40, 1'b0, 1'b1);
    tick();
    chk("follow40", f_pc, 32'h40);
    chk("hcnt1", btb_hit_count, 32'd1);

    // 3. Sequential redirect of the owner clears the entry
    redirect(32'h10, 32'h14);
    chk("clr_pc", f_pc, 32'h14);
    redirect(32'hC, 32'h10);
    chk_fetch("clr10", 32'h10, 32'h14, 1'b1, 1'b0);
    chk("clr_rcnt", redirect_count, 32'd4);

    // 4. Alias at the same index must not evict the 0x10 entry
    redirect(32'h10, 32'h40);
    redirect(32'h50, 32'h54);
    chk_fetch("alias54", 32'h54, 32'h58, 1'b1, 1'b0);
    redirect(32'hC, 32'h10);
    chk_fetch("alias10", 32'h10, 32'h40, 1'b0, 1'b1);
    chk("alias_rcnt", redirect_count, 32'd7);
    tick();
    chk("alias_hcnt", btb_hit_count, 32'd2);

    // 5. Stall holds the PC; redirect overrides stall and still trains
    redirect(32'h4, 32'h8);
    i_stall = 1'b1;
    tick();
    chk("stall1", f_pc, 32'h8);
    tick();
    chk("stall2", f_pc, 32'h8);
    redirect(32'h8, 32'h100);
    i_stall = 1'b0;
    chk_fetch("stall_redir", 32'h100, 32'h104, 1'b1, 1'b0);
    chk("stall_rcnt", redirect_count, 32'd9);
    redirect(32'h4, 32'h8);
    chk_fetch("stall_train", 32'h8, 32'h100, 1'b0, 1'b1);
    chk("stall_hcnt", btb_hit_count, 32'd2);

    // 6. Reset mid-run wins over a simultaneous redirect
    i_reset        = 1'b1;
    exec_ld_pc     = 1'b1;
    exec_br_origin = 32'h20;
    exec_br_pc     = 32'h80;
    tick();
    exec_ld_pc = 1'b0;
    i_reset    = 1'b0;
    chk_fetch("rst2", 32'h0, 32'h4, 1'b1, 1'b0);
    chk("rst2_rcnt", redirect_count, 32'd0);
    chk("rst2_hcnt", btb_hit_count, 32'd0);
    redirect(32'hC, 32'h10);
    chk_fetch("rst2_10", 32'h10, 32'h14, 1'b1, 1'b0);
    redirect(32'h4, 32'h8);
    chk_fetch("rst2_8", 32'h8, 32'hC, 1'b1, 1'b0);
    redirect(32'h1C, 32'h20);
    chk_fetch("rst2_20", 32'h20, 32'h24, 1'b1, 1'b0);
    chk("rst2_rcnt3", redirect_count, 32'd3);

    // Wrap at the top of the address space
    redirect(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    chk_fetch("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    tick();
    chk("wrap_next", f_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
